// File: rtl/modulation_sampler_seq.sv
// modulation_sampler_seq
//   Generates the read address into the modulation buffer. Once started, the
//   sequence is held off until SYS_TIME reaches a 2^SYNC_SHIFT boundary so that
//   every device on the network begins on the same tick. After that, ADDR
//   steps from 0 to MOD_CYCLE, holding each value for UPDATE_CYCLE clocks. The
//   sequence either loops forever or runs once and then pulses DONE.
//
// Optional build macro: MODULATION_SAMPLER_STRIDE_EN
//   When defined, this adds the STRIDE input. Each step then advances ADDR by
//   STRIDE, modulo MOD_CYCLE+1.
//
// Ports
//   CLK, RST_N    clock, asynchronous active-low reset
//   SYS_TIME      global synchronised time (64 bit)
//   MOD_CYCLE     last valid address, sampled at START
//   UPDATE_CYCLE  clocks per address step, sampled at START (0 acts as 1)
//   LOOP          1 = wrap forever, 0 = one-shot, sampled at START
//   START, STOP   single-cycle control requests (STOP has priority)
//   STRIDE        address increment, sampled at START (macro builds only)
//   ADDR          current buffer address
//   ADDR_VALID    ADDR is a live sample
//   BUSY          sequencer is armed or running
//   DONE          one-cycle pulse at the end of a one-shot sequence
module modulation_sampler_seq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DIV_WIDTH  = 32,
    parameter int SYNC_SHIFT = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [63:0]           SYS_TIME,
    input  logic [ADDR_WIDTH-1:0] MOD_CYCLE,
    input  logic [DIV_WIDTH-1:0]  UPDATE_CYCLE,
    input  logic                  LOOP,
    input  logic                  START,
    input  logic                  STOP,
`ifdef MODULATION_SAMPLER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] STRIDE,
`endif
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic                  ADDR_VALID,
    output logic                  BUSY,
    output logic                  DONE
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] mod_cycle_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [DIV_WIDTH-1:0]  update_cycle_q;
    logic [DIV_WIDTH-1:0]  presc;
    logic                  loop_q;

    logic [ADDR_WIDTH-1:0] stride_eff;
    logic [ADDR_WIDTH:0]   addr_sum;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  wrap;
    logic                  step;
    logic                  sync_hit;
    logic                  unused_sys_time;

    // Only the low SYNC_SHIFT bits of SYS_TIME matter for alignment.
    assign unused_sys_time = ^SYS_TIME[63:SYNC_SHIFT];

    always_comb begin
`ifdef MODULATION_SAMPLER_STRIDE_EN
        if (STRIDE == '0 || STRIDE > MOD_CYCLE)
            stride_eff = ADDR_WIDTH'(1);
        else
            stride_eff = STRIDE;
`else
        stride_eff = ADDR_WIDTH'(1);
`endif
    end

    // Compute the sum one bit wider than ADDR so that the wrap test is an
    // explicit compare rather than a modular overflow. With stride 1, this
    // reduces to ADDR==MOD_CYCLE -> 0.
    always_comb begin
        addr_sum = {1'b0, ADDR} + {1'b0, stride_q};
        wrap     = addr_sum > {1'b0, mod_cycle_q};
        if (wrap)
            addr_next = ADDR_WIDTH'(addr_sum - ({1'b0, mod_cycle_q} + (ADDR_WIDTH+1)'(1)));
        else
            addr_next = addr_sum[ADDR_WIDTH-1:0];
        step     = (presc == update_cycle_q - DIV_WIDTH'(1));
        sync_hit = (SYS_TIME[SYNC_SHIFT-1:0] == '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            ADDR           <= '0;
            ADDR_VALID     <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            presc          <= '0;
            mod_cycle_q    <= '0;
            update_cycle_q <= '0;
            stride_q       <= '0;
            loop_q         <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        mod_cycle_q    <= MOD_CYCLE;
                        update_cycle_q <= (UPDATE_CYCLE == '0) ? DIV_WIDTH'(1) : UPDATE_CYCLE;
                        loop_q         <= LOOP;
                        stride_q       <= stride_eff;
                        BUSY           <= 1'b1;
                        state          <= ARMED;
                    end
                end
                ARMED: begin
                    if (STOP) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (sync_hit) begin
                        ADDR       <= '0;
                        ADDR_VALID <= 1'b1;
                        presc      <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        ADDR_VALID <= 1'b0;
                        BUSY       <= 1'b0;
                        state      <= IDLE;
                    end else if (step) begin
                        presc <= '0;
                        if (wrap && !loop_q) begin
                            // One-shot ends here. ADDR keeps its last value.
                            ADDR_VALID <= 1'b0;
                            BUSY       <= 1'b0;
                            DONE       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            ADDR <= addr_next;
                        end
                    end else begin
                        presc <= presc + DIV_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modulation_sampler_seq.sv
module tb_modulation_sampler_seq;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   sys_time;
    logic [AW-1:0] mod_cycle;
    logic [DW-1:0] update_cycle;
    logic          loop;
    logic          start;
    logic          stop;
    logic [AW-1:0] stride;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          busy;
    logic          done;

    modulation_sampler_seq #(
        .ADDR_WIDTH(AW),
        .DIV_WIDTH (DW),
        .SYNC_SHIFT(SS)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .SYS_TIME    (sys_time),
        .MOD_CYCLE   (mod_cycle),
        .UPDATE_CYCLE(update_cycle),
        .LOOP        (loop),
        .START       (start),
        .STOP        (stop),
`ifdef MODULATION_SAMPLER_STRIDE_EN
        .STRIDE      (stride),
`endif
        .ADDR        (addr),
        .ADDR_VALID  (addr_valid),
        .BUSY        (busy),
        .DONE        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model. It tracks the phase (0 idle, 1 waiting for alignment,
    // 2 running) and the number of clocks since the run began. The expected
    // address is k*S mod (M+1), where k is the step index.
    int m_phase = 0;
    int m_M, m_U, m_L, m_S;
    int m_rc;
    int exp_addr = 0;
    bit exp_done = 0;

    int exp1[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int cap[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        exp_addr = 0;
        exp_done = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input logic [63:0] t);
        int k;
        exp_done = 0;
        case (m_phase)
            0: if (st && !sp) begin
                m_M = int'(mod_cycle);
                m_U = (update_cycle == 0) ? 1 : int'(update_cycle);
                m_L = int'(loop);
`ifdef MODULATION_SAMPLER_STRIDE_EN
                m_S = (stride == 0 || stride > mod_cycle) ? 1 : int'(stride);
`else
                m_S = 1;
`endif
                m_phase = 1;
            end
            1: if (sp) m_phase = 0;
               else if (t % (64'd1 << SS) == 0) begin
                   m_phase  = 2;
                   m_rc     = 0;
                   exp_addr = 0;
               end
            default: if (sp) m_phase = 0;
               else begin
                   m_rc++;
                   k = m_rc / m_U;
                   if (m_L == 0 && k > m_M / m_S) begin
                       m_phase  = 0;
                       exp_done = 1;
                   end else begin
                       exp_addr = (k * m_S) % (m_M + 1);
                   end
               end
        endcase
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_addr"},  addr,       exp_addr);
        chk({pfx, "_valid"}, addr_valid, m_phase == 2);
        chk({pfx, "_busy"},  busy,       m_phase != 0);
        chk({pfx, "_done"},  done,       exp_done);
    endtask

    task automatic cycle(input bit st, input bit sp);
        start = st;
        stop  = sp;
        @(posedge clk);
        model_edge(st, sp, sys_time);
        #1;
        check_outputs("cyc");
        sys_time = sys_time + 1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int m, input int u, input bit l, input int s);
        mod_cycle    = AW'(m);
        update_cycle = DW'(u);
        loop         = l;
        stride       = AW'(s);
    endtask

    task automatic run_until_addr(input int target, input int limit, output bit found);
        found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            cycle(1'b0, 1'b0);
            if (addr_valid === 1'b1 && addr === AW'(target)) found = 1;
        end
    endtask

    initial begin
        bit found;
        rst_n    = 1'b0;
        sys_time = 64'h0000_0001_0000_0003;
        start    = 1'b0;
        stop     = 1'b0;
        set_cfg(0, 0, 0, 0);
        model_reset();
        #12;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(3);

        // Looping M=3, U=2. Start with SYS_TIME[3:0]=5 and capture the sequence.
        set_cfg(3, 2, 1, 1);
        while (sys_time[3:0] != 4'd5) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("armed_busy", busy, 1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0);
            if (addr_valid === 1'b1 && cap.size() < 10) cap.push_back(int'(addr));
        end
        chk("seq1_len", cap.size(), 10);
        for (int i = 0; i < 10 && i < cap.size(); i++) chk("seq1", cap[i], exp1[i]);
        cycle(1'b0, 1'b1);
        idle_cycles(2);

        // One-shot with the same config, then a restart.
        set_cfg(3, 2, 0, 1);
        cycle(1'b1, 1'b0);
        set_cfg(7, 3, 1, 5);   // changes after START must not matter
        idle_cycles(40);
        chk("oneshot_addr_hold", addr, 3);
        set_cfg(3, 2, 0, 1);
        cycle(1'b1, 1'b0);
        idle_cycles(30);

        // UPDATE_CYCLE=0 behaves as 1.
        set_cfg(2, 0, 1, 1);
        cycle(1'b1, 1'b0);
        idle_cycles(24);

        // STOP while ADDR=2, then START and STOP together in idle.
        set_cfg(5, 1, 1, 1);
        run_until_addr(2, 64, found);
        chk("stop_reach", found, 1);
        cycle(1'b0, 1'b1);
        chk("stop_valid", addr_valid, 0);
        cycle(1'b1, 1'b1);
        idle_cycles(3);

        // MOD_CYCLE=0 one-shot.
        set_cfg(0, 3, 0, 1);
        cycle(1'b1, 1'b0);
        idle_cycles(24);

        // Asynchronous reset mid-run at ADDR=5.
        set_cfg(7, 1, 1, 1);
        cycle(1'b1, 1'b0);
        run_until_addr(5, 64, found);
        chk("rst_reach", found, 1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        sys_time = sys_time + 1;
        rst_n = 1'b1;
        idle_cycles(20);

`ifdef MODULATION_SAMPLER_STRIDE_EN
        set_cfg(4, 1, 1, 2);
        cycle(1'b1, 1'b0);
        idle_cycles(30);
        cycle(1'b0, 1'b1);
        set_cfg(4, 1, 0, 2);
        cycle(1'b1, 1'b0);
        idle_cycles(30);
`endif

        // Randomised traffic. Config inputs toggle freely every cycle.
        for (int i = 0; i < 1500; i++) begin
            set_cfg($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 9));
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
